// File: rtl/wfg_wb_master_pkg.sv
// Shared types for the waveform-generator Wishbone initiator.
// Holds the initiator FSM state encoding and the default ack timeout.
package wfg_wb_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/wfg_wb_master.sv
// Single-outstanding Wishbone classic initiator: one bus cycle per command,
// one response (read data + timeout error flag) per bus cycle.
// Ports: cmd_* valid/ready command stream in, rsp_* valid/ready response
// stream out, wbm_* Wishbone master bus, busy_o = not IDLE.
module wfg_wb_master
    import wfg_wb_master_pkg::*;
#(
    parameter int BUSW    = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [BUSW-1:0]   cmd_adr_i,
    input  logic [BUSW-1:0]   cmd_dat_i,
    input  logic [BUSW/8-1:0] cmd_sel_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [BUSW-1:0]   rsp_dat_o,
    output logic              rsp_err_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [BUSW/8-1:0] wbm_sel_o,
    output logic [BUSW-1:0]   wbm_adr_o,
    output logic [BUSW-1:0]   wbm_dat_o,
    input  logic              wbm_ack_i,
    input  logic [BUSW-1:0]   wbm_dat_i,
    output logic              busy_o
);

    localparam int TOW = $clog2(TIMEOUT + 1);
    localparam logic [TOW-1:0] LAST = TOW'(TIMEOUT - 1);

    state_t            state_q;
    logic [TOW-1:0]    cnt_q;
    logic [TOW-1:0]    cnt_d;
    logic              cyc_q;
    logic              we_q;
    logic [BUSW/8-1:0] sel_q;
    logic [BUSW-1:0]   adr_q;
    logic [BUSW-1:0]   dat_q;
    logic              rsp_valid_q;
    logic [BUSW-1:0]   rsp_dat_q;
    logic              rsp_err_q;

    assign cnt_d = cnt_q + 1'b1;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        we_q    <= cmd_we_i;
                        adr_q   <= cmd_adr_i;
                        dat_q   <= cmd_dat_i;
                        sel_q   <= cmd_sel_i;
                        cyc_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= BUS;
                    end
                end
                BUS: begin
                    // Ack takes priority over a timeout in the same cycle.
                    if (wbm_ack_i) begin
                        cyc_q       <= 1'b0;
                        rsp_dat_q   <= we_q ? '0 : wbm_dat_i;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (cnt_q == LAST) begin
                        cyc_q       <= 1'b0;
                        rsp_dat_q   <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: doc/wfg_wb_master.md
Name: wfg_wb_master

Overview:
- Single-outstanding Wishbone classic initiator that converts a valid/ready command stream into one Wishbone cycle per command.
- Returns a response stream carrying read data and an error flag.
- Sits between an on-chip sequencer/test controller and the waveform-generator register slaves (e.g. SPI driver CTRL/CFG/CLKCFG).
- Drives the same wbs_* bus those slaves consume.

Parameters:
- BUSW, 32, data and address width in bits; sel width is BUSW/8.
- TIMEOUT, 255, bus cycles to wait for ack before aborting; must be at least 1.
- TOW, $clog2(TIMEOUT+1), timeout counter width; derived, not overridden.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- cmd_valid_i  in  1  command available.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_we_i  in  1  1=write, 0=read.
- cmd_adr_i  in  BUSW  target address.
- cmd_dat_i  in  BUSW  write data.
- cmd_sel_i  in  BUSW/8  byte select.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumed when valid&ready.
- rsp_dat_o  out  BUSW  read data; 0 for writes and for timeouts.
- rsp_err_o  out  1  1 = timeout abort.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  BUSW/8  byte select.
- wbm_adr_o  out  BUSW  address.
- wbm_dat_o  out  BUSW  write data.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_dat_i  in  BUSW  slave read data.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0 except cmd_ready_o. State is IDLE. Timeout counter is 0.
- cmd_ready_o is combinational: it is 1 exactly when the state is IDLE, so it is 1 during reset.
- Reset mid-cycle drops cyc/stb immediately (asynchronous) and discards any pending response.
- The FSM has three states: IDLE, BUS, RESP. All outputs are registered except cmd_ready_o and busy_o, which decode the state.
- IDLE:
  - On cmd_valid_i, capture we/adr/dat/sel into the wbm_* registers.
  - Set cyc=stb=1, clear the counter, go to BUS.
  - Wishbone outputs are asserted from the cycle after acceptance.
- BUS:
  - Hold cyc, stb and all wbm_* outputs stable.
  - On wbm_ack_i: drop cyc/stb on the next edge. Load rsp_dat_o with wbm_dat_i for a read or 0 for a write. Set rsp_err_o=0, rsp_valid_o=1, go to RESP.
  - Otherwise increment the counter. When the counter equals TIMEOUT-1 with no ack: drop cyc/stb, set rsp_dat_o=0, rsp_err_o=1, rsp_valid_o=1, go to RESP.
  - If ack and the timeout condition occur in the same cycle, ack wins.
- RESP:
  - Hold rsp_* stable until rsp_ready_i. Then clear rsp_valid_o and go to IDLE.
  - A new command can be accepted on the cycle after the handshake.
- wbm_ack_i outside BUS is ignored, including a late ack after a timeout.
- Latency against a registered-ack slave (ack one cycle after stb):
  - accept at edge 0 -> cyc/stb high cycle 1 -> ack cycle 2 -> rsp_valid_o high cycle 3.
  - stb is low in cycle 3, satisfying the slave's no-back-to-back-ack rule.
  - Minimum command-to-command spacing is 4 cycles.
- wbm_dat_o and wbm_sel_o are driven for reads as well; slaves ignore them.
- An address that decodes to no slave is not an error here; only timeout sets rsp_err_o.

Decomposition:
- Package wfg_wb_master_pkg holds:
  - the state enum {IDLE, BUS, RESP} as logic [1:0];
  - localparam DEFAULT_TIMEOUT = 255.
- No sub-module; the FSM, timeout counter and capture registers all live in this one module.
- Benches pair it with wfg_drive_spi_wishbone_reg as the slave.

Test Plan:
1. Write then read with the SPI register slave.
   - Stimulus: write adr 4'h8 data 32'h0000_00A5 sel 4'hF, then read adr 4'h8.
   - Required: the write response has rsp_dat_o=0, err=0; the read response has rsp_dat_o=32'h0000_00A5, err=0; clkcfg_div_q_o=8'hA5.
   - Required: cyc/stb high for exactly 2 cycles per access; rsp_valid_o rises 3 cycles after acceptance.
2. Response backpressure.
   - Stimulus: hold rsp_ready_i=0 for 10 cycles after rsp_valid_o rises.
   - Required: rsp_* stable throughout; cmd_ready_o=0 and busy_o=1 until the handshake.
3. Timeout with TIMEOUT=4 and a stub slave that never acks.
   - Required: cyc/stb high for exactly 4 cycles; response has err=1, dat=0.
   - Required: a late ack injected 2 cycles afterward changes nothing.
4. Ack on the final timeout cycle (TIMEOUT=4, ack in bus cycle 4).
   - Required: err=0 and the captured read data is returned.
5. Reset mid-BUS.
   - Stimulus: assert wb_rst_i asynchronously while cyc=1.
   - Required: cyc/stb/rsp_valid_o fall without a clock edge; after release cmd_ready_o=1 and a new read of adr 4'h0 returns 0.
6. Back-to-back commands with cmd_valid_i held high for 3 commands.
   - Required: exactly 3 Wishbone cycles with no command dropped or duplicated; spacing 4 cycles with rsp_ready_i tied high.
